// File: rtl/net_eject_domain_buf.sv
// Ejection buffer behind a ring-network terminal port: steers each message
// into a per-domain FIFO so a stalled domain never blocks the other one.
module net_eject_domain_buf #(
  parameter int unsigned p_payload_cnbits = 32,
  parameter int unsigned p_payload_dnbits = 32,
  parameter int unsigned p_opaque_nbits   = 3,
  parameter int unsigned p_srcdest_nbits  = 3,
  parameter int unsigned p_num_entries    = 2,
  // control message = {dest, src, opaque, payload}
  localparam int unsigned c_net_msg_cnbits =
    p_payload_cnbits + p_opaque_nbits + 2 * p_srcdest_nbits,
  localparam int unsigned c_cnt_nbits = $clog2(p_num_entries + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic                        in_domain,
  input  logic [c_net_msg_cnbits-1:0] in_msg_control,
  input  logic [p_payload_dnbits-1:0] in_msg_data,
  output logic                        out0_val,
  input  logic                        out0_rdy,
  output logic [c_net_msg_cnbits-1:0] out0_msg_control,
  output logic [p_payload_dnbits-1:0] out0_msg_data,
  output logic                        out1_val,
  input  logic                        out1_rdy,
  output logic [c_net_msg_cnbits-1:0] out1_msg_control,
  output logic [p_payload_dnbits-1:0] out1_msg_data,
  output logic [c_cnt_nbits-1:0]      count0,
  output logic [c_cnt_nbits-1:0]      count1
);

  localparam int unsigned c_ptr_nbits   = $clog2(p_num_entries);
  localparam int unsigned c_entry_nbits = c_net_msg_cnbits + p_payload_dnbits;
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

  logic [c_entry_nbits-1:0] mem_q  [2][p_num_entries];
  logic [c_entry_nbits-1:0] mem_d  [2][p_num_entries];
  logic [c_ptr_nbits-1:0]   wr_ptr_q [2];
  logic [c_ptr_nbits-1:0]   wr_ptr_d [2];
  logic [c_ptr_nbits-1:0]   rd_ptr_q [2];
  logic [c_ptr_nbits-1:0]   rd_ptr_d [2];
  logic [c_cnt_nbits-1:0]   cnt_q  [2];
  logic [c_cnt_nbits-1:0]   cnt_d  [2];

  logic [1:0]               out_val;
  logic [1:0]               out_rdy;
  logic [c_entry_nbits-1:0] head [2];
  logic                     enq;

  assign out_rdy = {out1_rdy, out0_rdy};

  // Ready depends only on registered occupancy of the addressed domain,
  // never on the downstream ready of either channel.
  always_comb begin
    in_rdy = ((in_domain ? cnt_q[1] : cnt_q[0]) != c_full);
    enq    = in_val & in_rdy;
  end

  // Per-domain next-state: enqueue into the tagged FIFO, dequeue on handshake.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    out_val  = '0;
    for (int unsigned d = 0; d < 2; d++) begin
      logic do_enq;
      logic do_deq;
      out_val[d] = (cnt_q[d] != '0);
      head[d]    = out_val[d] ? mem_q[d][rd_ptr_q[d]] : '0;
      do_enq     = enq && (in_domain == d[0]);
      do_deq     = out_val[d] & out_rdy[d];
      if (do_enq) begin
        mem_d[d][wr_ptr_q[d]] = {in_msg_control, in_msg_data};
        wr_ptr_d[d]           = wr_ptr_q[d] + 1'b1;
      end
      if (do_deq) begin
        rd_ptr_d[d] = rd_ptr_q[d] + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   cnt_d[d] = cnt_q[d] + 1'b1;
        2'b01:   cnt_d[d] = cnt_q[d] - 1'b1;
        default: cnt_d[d] = cnt_q[d];
      endcase
    end
  end

  // State registers; storage contents need no reset since empty FIFOs
  // drive zeros on their outputs.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out0_val = out_val[0];
  assign out1_val = out_val[1];
  assign {out0_msg_control, out0_msg_data} = head[0];
  assign {out1_msg_control, out1_msg_data} = head[1];
  assign count0 = cnt_q[0];
  assign count1 = cnt_q[1];

endmodule

// File: tb/tb_net_eject_domain_buf.sv
// Directed bench for the per-domain ejection buffer.
module tb_net_eject_domain_buf;

  localparam int M  = 41;
  localparam int PD = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val, in_rdy, in_domain;
  logic [M-1:0]  in_msg_control;
  logic [PD-1:0] in_msg_data;
  logic          out0_val, out0_rdy, out1_val, out1_rdy;
  logic [M-1:0]  out0_msg_control, out1_msg_control;
  logic [PD-1:0] out0_msg_data, out1_msg_data;
  logic [1:0]    count0, count1;

  int total = 0;
  int bad   = 0;

  net_eject_domain_buf #(
    .p_payload_cnbits(32),
    .p_payload_dnbits(32),
    .p_opaque_nbits(3),
    .p_srcdest_nbits(3),
    .p_num_entries(2)
  ) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_domain(in_domain),
    .in_msg_control(in_msg_control), .in_msg_data(in_msg_data),
    .out0_val(out0_val), .out0_rdy(out0_rdy),
    .out0_msg_control(out0_msg_control), .out0_msg_data(out0_msg_data),
    .out1_val(out1_val), .out1_rdy(out1_rdy),
    .out1_msg_control(out1_msg_control), .out1_msg_data(out1_msg_data),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic dom, input logic [M-1:0] c, input logic [PD-1:0] d);
    in_val = 1'b1; in_domain = dom; in_msg_control = c; in_msg_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b0; in_domain = 1'b0;
    in_msg_control = '0; in_msg_data = '0; out0_rdy = 1'b0; out1_rdy = 1'b0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    total++; if (out0_val !== 1'b0) begin bad++; $display("FAIL reset_out0_val got=%b exp=0", out0_val); end
    total++; if (out1_val !== 1'b0) begin bad++; $display("FAIL reset_out1_val got=%b exp=0", out1_val); end
    total++; if (count0 !== 2'd0 || count1 !== 2'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count0, count1); end
    total++; if (out0_msg_data !== '0 || out0_msg_control !== '0) begin bad++; $display("FAIL reset_out0_data got=%h/%h exp=0", out0_msg_control, out0_msg_data); end
    total++; if (out1_msg_data !== '0 || out1_msg_control !== '0) begin bad++; $display("FAIL reset_out1_data got=%h/%h exp=0", out1_msg_control, out1_msg_data); end
  endtask

  task automatic test_single();
    out0_rdy = 1'b1; out1_rdy = 1'b0;
    offer(1'b0, 41'h11, 32'hA0);
    step();
    in_val = 1'b0;
    total++; if (out0_val !== 1'b1) begin bad++; $display("FAIL single_val got=%b exp=1", out0_val); end
    total++; if (out0_msg_data !== 32'hA0) begin bad++; $display("FAIL single_data got=%h exp=a0", out0_msg_data); end
    total++; if (out0_msg_control !== 41'h11) begin bad++; $display("FAIL single_ctrl got=%h exp=11", out0_msg_control); end
    total++; if (count0 !== 2'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count0); end
    total++; if (out1_val !== 1'b0) begin bad++; $display("FAIL single_out1_val got=%b exp=0", out1_val); end
    step();
    total++; if (count0 !== 2'd0) begin bad++; $display("FAIL single_drained got=%0d exp=0", count0); end
    total++; if (out0_val !== 1'b0 || out0_msg_data !== '0) begin bad++; $display("FAIL single_empty got=%b/%h exp=0/0", out0_val, out0_msg_data); end
  endtask

  task automatic test_full();
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    offer(1'b0, 41'h21, 32'hA0); step();
    offer(1'b0, 41'h22, 32'hA1); step();
    offer(1'b0, 41'h23, 32'hA2); #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL full_in_rdy got=%b exp=0", in_rdy); end
    total++; if (count0 !== 2'd2) begin bad++; $display("FAIL full_count got=%0d exp=2", count0); end
    step();
    total++; if (count0 !== 2'd2 || out0_msg_data !== 32'hA0) begin bad++; $display("FAIL full_hold got=%0d/%h exp=2/a0", count0, out0_msg_data); end
    offer(1'b1, 41'h31, 32'hB0); #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL other_dom_rdy got=%b exp=1", in_rdy); end
    step();
    total++; if (out1_val !== 1'b1 || out1_msg_data !== 32'hB0) begin bad++; $display("FAIL other_dom_out got=%b/%h exp=1/b0", out1_val, out1_msg_data); end
    total++; if (count1 !== 2'd1 || count0 !== 2'd2) begin bad++; $display("FAIL other_dom_counts got=%0d/%0d exp=2/1", count0, count1); end
    // Full domain being dequeued still refuses a new message this cycle.
    out0_rdy = 1'b1;
    offer(1'b0, 41'h24, 32'hA2); #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL full_deq_rdy got=%b exp=0", in_rdy); end
    step();
    in_val = 1'b0; out0_rdy = 1'b0;
    total++; if (count0 !== 2'd1 || out0_msg_data !== 32'hA1) begin bad++; $display("FAIL full_deq_head got=%0d/%h exp=1/a1", count0, out0_msg_data); end
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    step();
    total++; if (count0 !== 2'd0 || count1 !== 2'd0) begin bad++; $display("FAIL full_drain got=%0d/%0d exp=0/0", count0, count1); end
  endtask

  task automatic test_interleave();
    logic [PD-1:0] exp0[$];
    logic [PD-1:0] exp1[$];
    logic [PD-1:0] e;
    logic          dom;
    int            got0 = 0;
    int            got1 = 0;
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        dom = i[0];
        offer(dom, M'(32'h40 + i), (dom ? 32'hB0 : 32'hA0) + 32'(i / 2));
      end else begin
        in_val = 1'b0;
      end
      #1;
      total++;
      if (out0_val !== (exp0.size() != 0)) begin bad++; $display("FAIL ilv_val0 cyc=%0d got=%b exp=%b", i, out0_val, exp0.size() != 0); end
      if (out0_val === 1'b1 && exp0.size() != 0) begin
        e = exp0.pop_front(); got0++; total++;
        if (out0_msg_data !== e) begin bad++; $display("FAIL ilv_data0 cyc=%0d got=%h exp=%h", i, out0_msg_data, e); end
      end
      total++;
      if (out1_val !== (exp1.size() != 0)) begin bad++; $display("FAIL ilv_val1 cyc=%0d got=%b exp=%b", i, out1_val, exp1.size() != 0); end
      if (out1_val === 1'b1 && exp1.size() != 0) begin
        e = exp1.pop_front(); got1++; total++;
        if (out1_msg_data !== e) begin bad++; $display("FAIL ilv_data1 cyc=%0d got=%h exp=%h", i, out1_msg_data, e); end
      end
      if (in_val) begin
        total++;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL ilv_in_rdy cyc=%0d got=%b exp=1", i, in_rdy); end
        else if (in_domain) exp1.push_back(in_msg_data);
        else exp0.push_back(in_msg_data);
      end
      step();
    end
    total++; if (got0 != 8 || got1 != 8) begin bad++; $display("FAIL ilv_delivered got=%0d/%0d exp=8/8", got0, got1); end
  endtask

  task automatic test_simul();
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    offer(1'b0, 41'h50, 32'hC0); step();
    out0_rdy = 1'b1;
    offer(1'b0, 41'h33, 32'hC1); #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL simul_rdy got=%b exp=1", in_rdy); end
    step();
    in_val = 1'b0; out0_rdy = 1'b0;
    total++; if (count0 !== 2'd1) begin bad++; $display("FAIL simul_count got=%0d exp=1", count0); end
    total++; if (out0_msg_data !== 32'hC1 || out0_msg_control !== 41'h33) begin bad++; $display("FAIL simul_head got=%h/%h exp=33/c1", out0_msg_control, out0_msg_data); end
    out0_rdy = 1'b1; step();
    total++; if (count0 !== 2'd0) begin bad++; $display("FAIL simul_drain got=%0d exp=0", count0); end
  endtask

  task automatic test_reset_mid();
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    offer(1'b0, 41'h61, 32'hD0); step();
    offer(1'b1, 41'h62, 32'hE0); step();
    offer(1'b0, 41'h63, 32'hD1); step();
    offer(1'b1, 41'h64, 32'hE1); step();
    in_val = 1'b0; in_domain = 1'b0; #1;
    total++; if (count0 !== 2'd2 || count1 !== 2'd2) begin bad++; $display("FAIL mid_filled got=%0d/%0d exp=2/2", count0, count1); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL mid_full_rdy got=%b exp=0", in_rdy); end
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (count0 !== 2'd0 || count1 !== 2'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", count0, count1); end
    total++; if (out0_val !== 1'b0 || out1_val !== 1'b0) begin bad++; $display("FAIL mid_vals got=%b/%b exp=0/0", out0_val, out1_val); end
    total++; if (out0_msg_data !== '0 || out1_msg_data !== '0 || out0_msg_control !== '0 || out1_msg_control !== '0) begin bad++; $display("FAIL mid_data got=%h/%h exp=0/0", out0_msg_data, out1_msg_data); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL mid_in_rdy got=%b exp=1", in_rdy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_interleave();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
